// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM states and default widths.
// Used by axi4lite_master_ctrl and axi4lite_slave.
package axi4lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } axi_mst_state_e;

endpackage

// File: rtl/axi4lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI read or write out, one response back.
// Optional AXI4LITE_ADDR_CHECK_EN rejects misaligned/out-of-window addresses locally with DECERR.
module axi4lite_master_ctrl
    import axi4lite_pkg::*;
#(
    parameter int                ADDR_W    = AXI_ADDR_W,
    parameter int                DATA_W    = AXI_DATA_W,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = 32'h0001_0000
) (
    input  logic              aclk,
    input  logic              arestn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    axi_mst_state_e state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;

    logic accept, addr_err, aw_ok, w_ok;

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a >= ADDR_BASE) && ((a - ADDR_BASE) < ADDR_SIZE);
    endfunction

`ifdef AXI4LITE_ADDR_CHECK_EN
    assign addr_err = !addr_legal(cmd_addr);
`else
    assign addr_err = 1'b0;
`endif

    // cmd_ready_q is low in the first IDLE cycle after reset, so accept must use it
    assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign aw_ok  = !awvalid_q || awready;
    assign w_ok   = !wvalid_q  || wready;

    always_ff @(posedge aclk or negedge arestn) begin
        if (!arestn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = addr_err ? RSP : (cmd_write ? WR_REQ : RD_ADDR);
            RD_ADDR: if (arready) state_d = RD_DATA;
            RD_DATA: if (rvalid) state_d = RSP;
            WR_REQ:  if (aw_ok && w_ok) state_d = WR_RESP;
            WR_RESP: if (bvalid) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so every port comes straight from a flop
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        arvalid_d   = (state_d == RD_ADDR);
        rready_d    = (state_d == RD_DATA);
        awvalid_d   = (state_d == WR_REQ) && ((state_q == IDLE) || (awvalid_q && !awready));
        wvalid_d    = (state_d == WR_REQ) && ((state_q == IDLE) || (wvalid_q && !wready));
        bready_d    = (state_d == WR_RESP);
        rsp_valid_d = (state_d == RSP);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        if (accept) begin
            addr_d      = cmd_addr;
            wdata_d     = cmd_wdata;
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_DECERR;
        end
        if (state_q == RD_DATA && rvalid) begin
            rsp_rdata_d = rdata;
            rsp_resp_d  = rresp;
        end
        if (state_q == WR_RESP && bvalid) begin
            rsp_rdata_d = '0;
            rsp_resp_d  = bresp;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign rready    = rready_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign bready    = bready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// Directed bench for axi4lite_master_ctrl; the slave side is driven cycle by cycle from each task.
// Build with AXI4LITE_ADDR_CHECK_EN to exercise the local address rejection path.
module tb_axi4lite_master_ctrl;

    logic        aclk = 1'b0;
    logic        arestn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;

    int tests = 0;
    int fails = 0;

    axi4lite_master_ctrl dut (
        .aclk(aclk), .arestn(arestn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if ({cmd_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid} !== 7'b0) begin fails++; $display("FAIL reset_ctrl: got %b exp 0000000", {cmd_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid}); end
        tests++; if ({araddr, awaddr, wdata, rsp_rdata, rsp_resp} !== 130'b0) begin fails++; $display("FAIL reset_data: got nonzero exp 0"); end
        tick();
        arestn = 1'b1;
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_early: got %b exp 0", cmd_ready); end
        tick();
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_read_basic();
        arready = 1'b1;
        issue(1'b0, 32'h10, 32'h0);
        tests++; if ({arvalid, cmd_ready, araddr} !== {1'b1, 1'b0, 32'h10}) begin fails++; $display("FAIL rd_addr_phase: got v=%b cr=%b a=%h exp 1 0 10", arvalid, cmd_ready, araddr); end
        tick();
        arready = 1'b0;
        tests++; if ({arvalid, rready, rsp_valid} !== 3'b010) begin fails++; $display("FAIL rd_data_phase: got %b exp 010", {arvalid, rready, rsp_valid}); end
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        tests++; if ({rsp_valid, rready} !== 2'b10) begin fails++; $display("FAIL rd_rsp_valid: got %b exp 10", {rsp_valid, rready}); end
        tests++; if (rsp_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL rd_rdata: got %h exp cafef00d", rsp_rdata); end
        tests++; if (rsp_resp !== 2'b00) begin fails++; $display("FAIL rd_resp: got %b exp 00", rsp_resp); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rd_back_idle: got %b exp 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_write_aw_delay();
        wready = 1'b1; awready = 1'b0;
        issue(1'b1, 32'h20, 32'h1234_5678);
        tests++; if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 32'h20, 32'h1234_5678}) begin fails++; $display("FAIL wr_req_start: got %b%b %h %h exp 11 20 12345678", awvalid, wvalid, awaddr, wdata); end
        tick();
        wready = 1'b0;
        tests++; if ({awvalid, wvalid, bready} !== 3'b100) begin fails++; $display("FAIL wr_w_drop: got %b exp 100", {awvalid, wvalid, bready}); end
        tick();
        tests++; if ({awvalid, wvalid, bready, awaddr} !== {3'b100, 32'h20}) begin fails++; $display("FAIL wr_aw_hold: got %b %h exp 100 20", {awvalid, wvalid, bready}, awaddr); end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        tests++; if ({awvalid, wvalid, bready} !== 3'b001) begin fails++; $display("FAIL wr_bready: got %b exp 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        tests++; if ({rsp_valid, bready, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h0}) begin fails++; $display("FAIL wr_rsp: got v=%b b=%b r=%b d=%h exp 1 0 00 0", rsp_valid, bready, rsp_resp, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_back_idle: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_error_resp();
        issue(1'b1, 32'h40, 32'hAAAA_5555);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        tests++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b1100) begin fails++; $display("FAIL wr_early_b_ignored: got %b exp 1100", {awvalid, wvalid, bready, rsp_valid}); end
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        tests++; if ({awvalid, wvalid, bready} !== 3'b001) begin fails++; $display("FAIL wr_both_hs: got %b exp 001", {awvalid, wvalid, bready}); end
        tick();
        bvalid = 1'b0;
        tests++; if ({rsp_valid, rsp_resp} !== {1'b1, 2'b10}) begin fails++; $display("FAIL wr_slverr: got %b %b exp 1 10", rsp_valid, rsp_resp); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        issue(1'b0, 32'h44, 32'h0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
        tick();
        tests++; if ({arvalid, rready, rsp_valid} !== 3'b100) begin fails++; $display("FAIL rd_early_r_ignored: got %b exp 100", {arvalid, rready, rsp_valid}); end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        tick();
        rvalid = 1'b0;
        tests++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b11, 32'hDEAD_BEEF}) begin fails++; $display("FAIL rd_decerr: got %b %b %h exp 1 11 deadbeef", rsp_valid, rsp_resp, rsp_rdata); end
    endtask

    task automatic test_rsp_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if ({rsp_valid, cmd_ready, rsp_resp, rsp_rdata} !== {2'b10, 2'b11, 32'hDEAD_BEEF}) begin fails++; $display("FAIL rsp_hold_%0d: got v=%b cr=%b r=%b d=%h exp 1 0 11 deadbeef", i, rsp_valid, cmd_ready, rsp_resp, rsp_rdata); end
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rsp_release: got %b exp 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_reset_mid();
        arready = 1'b1;
        issue(1'b0, 32'h80, 32'h0);
        tick();
        arready = 1'b0;
        tests++; if (rready !== 1'b1) begin fails++; $display("FAIL mid_in_rd_data: got %b exp 1", rready); end
        #2 arestn = 1'b0;
        #1;
        tests++; if ({arvalid, rready, rsp_valid, cmd_ready} !== 4'b0000) begin fails++; $display("FAIL mid_abort: got %b exp 0000", {arvalid, rready, rsp_valid, cmd_ready}); end
        tick();
        arestn = 1'b1;
        tick();
        tests++; if ({cmd_ready, rsp_valid, arvalid} !== 3'b100) begin fails++; $display("FAIL mid_recover: got %b exp 100", {cmd_ready, rsp_valid, arvalid}); end
    endtask

    task automatic test_addr_window();
`ifdef AXI4LITE_ADDR_CHECK_EN
        issue(1'b0, 32'h0002_0000, 32'h0);
        tests++; if ({arvalid, rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b11, 32'h0}) begin fails++; $display("FAIL chk_range: got a=%b v=%b r=%b d=%h exp 0 1 11 0", arvalid, rsp_valid, rsp_resp, rsp_rdata); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        issue(1'b0, 32'h3, 32'h0);
        tests++; if ({arvalid, rsp_valid, rsp_resp} !== {2'b01, 2'b11}) begin fails++; $display("FAIL chk_align: got a=%b v=%b r=%b exp 0 1 11", arvalid, rsp_valid, rsp_resp); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`else
        issue(1'b0, 32'h0002_0000, 32'h0);
        tests++; if ({arvalid, araddr, rsp_valid} !== {1'b1, 32'h0002_0000, 1'b0}) begin fails++; $display("FAIL nochk_pass: got %b %h %b exp 1 00020000 0", arvalid, araddr, rsp_valid); end
        arready = 1'b1; tick(); arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0; rresp = 2'b00; tick(); rvalid = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`endif
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL window_idle: got %b exp 1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_aw_delay();
        test_error_resp();
        test_rsp_backpressure();
        test_reset_mid();
        test_addr_window();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4lite_master_ctrl.md
Name:
axi4lite_master_ctrl

Overview:
Single-outstanding AXI4-Lite master controller. It turns simple command/response requests from a local requester (a NoC endpoint or config engine) into AXI4-Lite read or write transactions on the fabric towards our axi4lite slaves. It sequences all five channels with one FSM and returns data and response to the requester.

Parameters:
ADDR_W, 32, AXI and command address width
DATA_W, 32, AXI and command data width
ADDR_BASE, 32'h0000_0000, lowest legal address (only used with AXI4LITE_ADDR_CHECK_EN)
ADDR_SIZE, 32'h0001_0000, legal window size in bytes (only used with AXI4LITE_ADDR_CHECK_EN)

Ports:
aclk  in  1  clock
arestn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  requester takes response
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  2  AXI response code
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  DATA_W  read data
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_W  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  DATA_W  write data
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- All outputs are registered. While arestn is low: state=IDLE; all valid, ready and data outputs are 0, including cmd_ready.
- cmd_ready=1 only in IDLE. It rises on the first aclk edge after reset release.
- Response codes: 00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR. Codes from the slave pass through unchanged.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE: on cmd_valid&cmd_ready, latch addr/data. Next cycle enter RD_ADDR (arvalid=1) or WR_REQ (awvalid=1 and wvalid=1 together).
- RD_ADDR: hold arvalid/araddr stable until arready. Then RD_DATA with rready=1. On rvalid, capture rdata/rresp, drop rready, go to RSP.
- WR_REQ: awvalid and wvalid each drop independently on their own handshake and never reassert. When both handshakes are complete (same cycle or different cycles), go to WR_RESP with bready=1. On bvalid, capture bresp, go to RSP. rsp_rdata=0 for writes.
- Outputs never drop a valid before its handshake. Address and data are never changed while their valid is high.
- Slave responses arriving before their channel is active (rvalid in RD_ADDR, bvalid in WR_REQ) are ignored.
- RSP: rsp_valid=1 with rsp_rdata/rsp_resp held until rsp_ready, then IDLE with cmd_ready=1 the next cycle.
- Minimum latency with an always-ready slave: accept at cycle 0, AXI valid at 1, response captured at 2, rsp_valid at 3. Read and write are the same.
- Reset mid-transaction aborts immediately to IDLE with all outputs 0. No response is produced.

Optional Feature:
AXI4LITE_ADDR_CHECK_EN: an accepted command whose address is misaligned (addr[1:0]!=0) or outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) goes straight from IDLE to RSP with rsp_resp=11 (DECERR) and rsp_rdata=0. No AXI transaction is issued. Without the macro, every address goes to the bus and ADDR_BASE/ADDR_SIZE are unused.

Decomposition:
Package axi4lite_pkg holds the RESP_OKAY/EXOKAY/SLVERR/DECERR constants, the state enum and the default widths; it is shared with axi4lite_slave. No sub-module: this is one FSM with capture registers.

Test Plan:
- Read 0x10, slave asserts arready at once and rvalid next cycle with 0xCAFE_F00D, OKAY -> rsp_valid 3 cycles after accept, rsp_rdata=0xCAFE_F00D, rsp_resp=00.
- Write 0x20 = 0x1234_5678, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held stable 3 cycles, bready only after both handshakes, rsp_resp=00.
- Write with bresp=10 and read with rresp=11 -> rsp_resp 10 and 11 respectively.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp data stable for 5 cycles, cmd_ready=0 throughout.
- arestn pulsed low while in RD_DATA -> arvalid/rready/rsp_valid=0 immediately, cmd_ready=1 one cycle after release.
- With AXI4LITE_ADDR_CHECK_EN, read 0x2_0000 and 0x3 -> no arvalid, rsp_resp=11 within 2 cycles of accept.
